// File: rtl/instruction_stream_loader.sv
// Length-prefixed byte-stream loader: assembles little-endian words and writes them to instruction memory.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module instruction_stream_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_byte,
  output logic                  o_write_enable,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic                  o_busy,
  output logic                  o_core_hold,
  output logic                  o_load_done,
  output logic [7:0]            o_words_loaded,
  output logic                  o_checksum_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COUNT, ASSEMBLE, CHECK, DONE} state_t;
  logic [7:0] sum;
  logic       checksum_err;
`else
  typedef enum logic [2:0] {IDLE, COUNT, ASSEMBLE, DONE} state_t;
`endif

  state_t                state;
  logic [BW-1:0]         byte_idx;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [7:0]            target;
  logic [DATA_WIDTH-1:0] word_buf;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  last_lane;
  logic                  last_word;

  // Merge the incoming byte into its lane so the word can be written on the final byte's edge.
  always_comb begin
    word_next = word_buf;
    for (int unsigned k = 0; k < BYTES; k++) begin
      if (byte_idx == BW'(k)) word_next[8*k +: 8] = i_rx_byte;
    end
  end

  assign last_lane   = (byte_idx == BW'(BYTES - 1));
  assign last_word   = ((o_words_loaded + 8'd1) == target);
  assign o_core_hold = o_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      byte_idx       <= '0;
      word_idx       <= '0;
      target         <= '0;
      word_buf       <= '0;
      o_write_enable <= 1'b0;
      o_address      <= '0;
      o_instruction  <= '0;
      o_busy         <= 1'b0;
      o_load_done    <= 1'b0;
      o_words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum            <= '0;
      checksum_err   <= 1'b0;
`endif
    end else begin
      o_write_enable <= 1'b0;
      if (i_start) begin
        state          <= COUNT;
        o_busy         <= 1'b1;
        o_load_done    <= 1'b0;
        o_words_loaded <= '0;
        byte_idx       <= '0;
        word_idx       <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum            <= '0;
        checksum_err   <= 1'b0;
`endif
      end else if (i_rx_valid) begin
        case (state)
          COUNT: begin
            if (i_rx_byte == 8'd0 || i_rx_byte > 8'(DEPTH)) target <= 8'(DEPTH);
            else                                            target <= i_rx_byte;
            state <= ASSEMBLE;
`ifdef LOADER_CHECKSUM_EN
            sum   <= i_rx_byte;
`endif
          end
          ASSEMBLE: begin
            word_buf <= word_next;
`ifdef LOADER_CHECKSUM_EN
            sum      <= sum + i_rx_byte;
`endif
            if (last_lane) begin
              byte_idx       <= '0;
              o_write_enable <= 1'b1;
              o_instruction  <= word_next;
              o_address      <= word_idx;
              o_words_loaded <= o_words_loaded + 8'd1;
              if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                state       <= CHECK;
`else
                state       <= DONE;
                o_busy      <= 1'b0;
                o_load_done <= 1'b1;
`endif
              end else begin
                word_idx <= word_idx + ADDR_WIDTH'(1);
              end
            end else begin
              byte_idx <= byte_idx + BW'(1);
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHECK: begin
            state        <= DONE;
            o_busy       <= 1'b0;
            o_load_done  <= 1'b1;
            checksum_err <= (i_rx_byte != sum);
          end
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign o_checksum_err = checksum_err;
`else
  assign o_checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_stream_loader.sv
// Directed self-checking bench for instruction_stream_loader (DATA_WIDTH=32, ADDR_WIDTH=3, DEPTH=8).
// Works in both builds; the checksum scenarios run only when LOADER_CHECKSUM_EN is defined.
module tb_instruction_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_rx_valid;
  logic [7:0]  i_rx_byte;
  logic        o_write_enable;
  logic [2:0]  o_address;
  logic [31:0] o_instruction;
  logic        o_busy;
  logic        o_core_hold;
  logic        o_load_done;
  logic [7:0]  o_words_loaded;
  logic        o_checksum_err;

  instruction_stream_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte),
    .o_write_enable(o_write_enable), .o_address(o_address), .o_instruction(o_instruction),
    .o_busy(o_busy), .o_core_hold(o_core_hold), .o_load_done(o_load_done),
    .o_words_loaded(o_words_loaded), .o_checksum_err(o_checksum_err)
  );

  always #5 clk = ~clk;

`ifdef LOADER_CHECKSUM_EN
  localparam logic DONE_AT_WRITE = 1'b0;
`else
  localparam logic DONE_AT_WRITE = 1'b1;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned wr_cnt   = 0;
  logic [2:0]  wr_addr [0:31];
  logic [31:0] wr_data [0:31];
  int unsigned wr_cyc  [0:31];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_write_enable && wr_cnt < 32) begin
      wr_addr[wr_cnt] = o_address;
      wr_data[wr_cnt] = o_instruction;
      wr_cyc[wr_cnt]  = cyc;
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1; i_rx_byte = b;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_checksum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
    send_byte(b);
`else
    if (b == 8'hFF) tick();
`endif
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_byte = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: reset mid-load
    pulse_start();
    send_byte(8'h01); send_byte(8'h13); send_byte(8'h82);
    rst = 1'b1; tick(); tick();
    check("rst_we",    {31'b0, o_write_enable}, 32'd0);
    check("rst_addr",  {29'b0, o_address}, 32'd0);
    check("rst_instr", o_instruction, 32'd0);
    check("rst_busy",  {30'b0, o_busy, o_core_hold}, 32'd0);
    check("rst_done",  {31'b0, o_load_done}, 32'd0);
    check("rst_words", {24'b0, o_words_loaded}, 32'd0);
    check("rst_err",   {31'b0, o_checksum_err}, 32'd0);
    check("rst_nowr",  wr_cnt, 32'd0);
    rst = 1'b0;
    tick();
    send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("idle_ignore", wr_cnt, 32'd0);

    // 2: single word, write exactly one cycle after the last byte
    pulse_start();
    check("start_busy", {30'b0, o_busy, o_core_hold}, 32'd3);
    send_byte(8'h01); send_byte(8'h33); send_byte(8'h02); send_byte(8'h21);
    check("pre_we", {31'b0, o_write_enable}, 32'd0);
    send_byte(8'h00);
    check("w1_we",    {31'b0, o_write_enable}, 32'd1);
    check("w1_addr",  {29'b0, o_address}, 32'd0);
    check("w1_instr", o_instruction, 32'h00210233);
    check("w1_done",  {31'b0, o_load_done}, {31'b0, DONE_AT_WRITE});
    check("w1_words", {24'b0, o_words_loaded}, 32'd1);
    check("w1_busy",  {31'b0, o_busy}, {31'b0, ~DONE_AT_WRITE});
    send_checksum(8'h57);
    tick();
    check("w1_we_drop", {31'b0, o_write_enable}, 32'd0);
    check("w1_instr_hold", o_instruction, 32'h00210233);
    check("w1_done_lvl", {31'b0, o_load_done}, 32'd1);

    // 3: count 0 -> DEPTH words streamed back-to-back
    wr_cnt = 0;
    pulse_start();
    check("restart_clr", {23'b0, o_load_done, o_words_loaded}, 32'd0);
    send_byte(8'h00);
    for (int i = 0; i < 32; i++) send_byte(8'(i));
    send_checksum(8'hF0);
    for (int i = 0; i < 5; i++) send_byte(8'hEE);
    tick();
    check("b2b_count", wr_cnt, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("b2b_addr", {29'b0, wr_addr[i]}, 32'(i));
      if (i > 0) check("b2b_gap", wr_cyc[i] - wr_cyc[i-1], 32'd4);
    end
    check("b2b_w0", wr_data[0], 32'h03020100);
    check("b2b_w7", wr_data[7], 32'h1F1E1D1C);
    check("b2b_words", {24'b0, o_words_loaded}, 32'd8);
    check("b2b_done", {31'b0, o_load_done}, 32'd1);

    // 4: count above DEPTH is clamped
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h09);
    for (int i = 0; i < 36; i++) send_byte(8'h11);
    send_checksum(8'h6D);
    tick();
    check("clamp_count", wr_cnt, 32'd8);
    check("clamp_words", {24'b0, o_words_loaded}, 32'd8);
    check("clamp_done",  {30'b0, o_load_done, o_busy}, 32'd2);
    check("clamp_last",  {29'b0, wr_addr[7]}, 32'd7);

    // 5: abort mid-word, restart with a simultaneous byte that must be dropped
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h02); send_byte(8'h13); send_byte(8'h82);
    i_start = 1'b1; i_rx_valid = 1'b1; i_rx_byte = 8'h05;
    tick();
    i_start = 1'b0; i_rx_valid = 1'b0;
    check("abort_words", {24'b0, o_words_loaded}, 32'd0);
    send_byte(8'h01); send_byte(8'h13); send_byte(8'h82); send_byte(8'h20); send_byte(8'h00);
    send_checksum(8'hB6);
    tick(); tick();
    check("abort_count", wr_cnt, 32'd1);
    check("abort_addr",  {29'b0, wr_addr[0]}, 32'd0);
    check("abort_data",  wr_data[0], 32'h00208213);
    check("abort_words2", {24'b0, o_words_loaded}, 32'd1);
    check("abort_done",  {31'b0, o_load_done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum pass then fail
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      send_byte(8'h01); send_byte(8'h13); send_byte(8'h82); send_byte(8'h20); send_byte(8'h00);
      check("ck_wait", {30'b0, o_busy, o_load_done}, 32'd2);
      tick();
      check("ck_hold", {30'b0, o_busy, o_load_done}, 32'd2);
      send_byte(r == 0 ? 8'hB6 : 8'hB7);
      check("ck_done", {30'b0, o_busy, o_load_done}, 32'd1);
      check("ck_err",  {31'b0, o_checksum_err}, 32'(r));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
